// File: rtl/rx_frame_chk.sv
`timescale 1ns/1ps
// rx_frame_chk
// Purpose: UART RX frame checker. Consumes mid-bit samples from the RX sampler
//   and follows one frame: start bit, DATA_WIDTH data bits (LSB first), an
//   optional parity bit and STOP_BITS stop bits. It reports start, parity and
//   stop errors, and hands the received word on to the deserialiser.
// Parameters:
//   DATA_WIDTH     data bits per frame (5..9)
//   STOP_BITS      stop bits checked per frame (1 or 2)
// Ports:
//   i_clk, i_rst   clock (rising edge) and asynchronous active-high reset
//   i_frame_start  pulse: a falling edge was detected on the RX line
//   i_sample_valid pulse: i_sampled_bit holds the current mid-bit value
//   i_sampled_bit  majority-voted sample of the current bit
//   i_par_en       1 = frame carries a parity bit (latched at frame start)
//   i_par_type     0 = even, 1 = odd parity (latched at frame start)
//   o_data         last good word, held until the next good frame
//   o_data_valid   pulse: good frame received, o_data updated
//   o_str_err      pulse: start sample was 1
//   o_par_err      pulse: parity mismatch
//   o_stp_err      pulse: a stop sample was 0
//   o_busy         high while a frame is in progress
//   i_err_clr      clear sticky error flags     (RX_ERR_STICKY_EN only)
//   o_err_sticky   sticky {stp, par, str} flags (RX_ERR_STICKY_EN only)
// Configuration macro: RX_ERR_STICKY_EN adds the sticky error flags.
module rx_frame_chk #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_frame_start,
    input  logic                  i_sample_valid,
    input  logic                  i_sampled_bit,
    input  logic                  i_par_en,
    input  logic                  i_par_type,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_str_err,
    output logic                  o_par_err,
    output logic                  o_stp_err,
`ifdef RX_ERR_STICKY_EN
    input  logic                  i_err_clr,
    output logic [2:0]            o_err_sticky,
`endif
    output logic                  o_busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt, cnt_next;
    logic [DATA_WIDTH-1:0] shift, shift_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic                  par_en, par_en_next;
    logic                  par_type, par_type_next;
    logic                  par_err, par_err_next;
    logic                  stp_err, stp_err_next;
    logic                  valid_next, str_next, par_pulse_next, stp_pulse_next;
    logic                  par_expect;
`ifdef RX_ERR_STICKY_EN
    logic [2:0]            sticky, sticky_next;
`endif

    // Parity is evaluated on the fully assembled word while in PARITY.
    assign par_expect = par_type ? ~^shift : ^shift;
    assign o_busy     = (state != IDLE);

    // Next-state and next-output logic. The bit counter is reused to count
    // stop bits, since it is cleared on leaving DATA.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        shift_next     = shift;
        data_next      = o_data;
        par_en_next    = par_en;
        par_type_next  = par_type;
        par_err_next   = par_err;
        stp_err_next   = stp_err;
        valid_next     = 1'b0;
        str_next       = 1'b0;
        par_pulse_next = 1'b0;
        stp_pulse_next = 1'b0;

        case (state)
            IDLE: begin
                if (i_frame_start) begin
                    state_next    = START;
                    par_en_next   = i_par_en;
                    par_type_next = i_par_type;
                    par_err_next  = 1'b0;
                    stp_err_next  = 1'b0;
                    cnt_next      = '0;
                end
            end
            START: begin
                if (i_sample_valid) begin
                    if (i_sampled_bit) begin
                        str_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        cnt_next   = '0;
                    end
                end
            end
            DATA: begin
                if (i_sample_valid) begin
                    shift_next = {i_sampled_bit, shift[DATA_WIDTH-1:1]};
                    if (cnt == LAST_DATA) begin
                        cnt_next   = '0;
                        state_next = par_en ? PARITY : STOP;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (i_sample_valid) begin
                    if (i_sampled_bit != par_expect) begin
                        par_err_next = 1'b1;
                    end
                    state_next = STOP;
                end
            end
            STOP: begin
                if (i_sample_valid) begin
                    if (!i_sampled_bit) begin
                        stp_err_next = 1'b1;
                    end
                    if (cnt == LAST_STOP) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                        if (!(par_err || stp_err_next)) begin
                            data_next  = shift;
                            valid_next = 1'b1;
                        end else begin
                            par_pulse_next = par_err;
                            stp_pulse_next = stp_err_next;
                        end
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

`ifdef RX_ERR_STICKY_EN
        // A clear loses against an error reported in the same cycle.
        sticky_next = (i_err_clr ? 3'b000 : sticky)
                    | {stp_pulse_next, par_pulse_next, str_next};
`endif
    end

    // State and registered outputs; reset aborts any frame without a pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shift        <= '0;
            par_en       <= 1'b0;
            par_type     <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_str_err    <= 1'b0;
            o_par_err    <= 1'b0;
            o_stp_err    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            shift        <= shift_next;
            par_en       <= par_en_next;
            par_type     <= par_type_next;
            par_err      <= par_err_next;
            stp_err      <= stp_err_next;
            o_data       <= data_next;
            o_data_valid <= valid_next;
            o_str_err    <= str_next;
            o_par_err    <= par_pulse_next;
            o_stp_err    <= stp_pulse_next;
        end
    end

`ifdef RX_ERR_STICKY_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sticky <= 3'b000;
        end else begin
            sticky <= sticky_next;
        end
    end

    assign o_err_sticky = sticky;
`endif

endmodule

// File: tb/tb_rx_frame_chk.sv
`timescale 1ns/1ps
// tb_rx_frame_chk
// Purpose: self-checking bench for rx_frame_chk. Two instances are used: dut1
//   with one stop bit and dut2 with two stop bits. Each frame's expected
//   completion event (flags, o_data, cycle) is queued when its final sample
//   is driven; a monitor pops and compares whenever a DUT raises a pulse.
// Ports: none (top-level bench). Honours RX_ERR_STICKY_EN for sticky checks.
module tb_rx_frame_chk;

    typedef struct {
        logic       v;
        logic       s;
        logic       p;
        logic       t;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs1, sv1, sb1, pe1, pt1;
    logic       fs2, sv2, sb2, pe2, pt2;
    logic [7:0] data1, data2;
    logic       valid1, str1, par1, stp1, busy1;
    logic       valid2, str2, par2, stp2, busy2;
`ifdef RX_ERR_STICKY_EN
    logic       clr1, clr2;
    logic [2:0] sticky1, sticky2;
`endif

    exp_t       q1[$];
    exp_t       q2[$];
    int         compared = 0;
    int         mismatched = 0;
    int         cyc = 0;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last2 = 8'h00;

    always #5 clk = ~clk;

    // Free-running cycle counter used to check the completion latency.
    always @(posedge clk) cyc <= cyc + 1;

    rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs1), .i_sample_valid(sv1),
        .i_sampled_bit(sb1), .i_par_en(pe1), .i_par_type(pt1),
        .o_data(data1), .o_data_valid(valid1), .o_str_err(str1),
        .o_par_err(par1), .o_stp_err(stp1),
`ifdef RX_ERR_STICKY_EN
        .i_err_clr(clr1), .o_err_sticky(sticky1),
`endif
        .o_busy(busy1)
    );

    rx_frame_chk #(.DATA_WIDTH(8), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_frame_start(fs2), .i_sample_valid(sv2),
        .i_sampled_bit(sb2), .i_par_en(pe2), .i_par_type(pt2),
        .o_data(data2), .o_data_valid(valid2), .o_str_err(str2),
        .o_par_err(par2), .o_stp_err(stp2),
`ifdef RX_ERR_STICKY_EN
        .i_err_clr(clr2), .o_err_sticky(sticky2),
`endif
        .o_busy(busy2)
    );

    // Scoreboard monitor: any pulse must match the oldest queued event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (valid1 | str1 | par1 | stp1) begin
                compared++;
                if (q1.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL dut1_unexpected_pulse got vspt=%b%b%b%b want none",
                             valid1, str1, par1, stp1);
                end else begin
                    e = q1.pop_front();
                    if ({valid1, str1, par1, stp1} !== {e.v, e.s, e.p, e.t}) begin
                        mismatched++;
                        $display("[TB] FAIL dut1_flags got vspt=%b%b%b%b want %b%b%b%b",
                                 valid1, str1, par1, stp1, e.v, e.s, e.p, e.t);
                    end
                    compared++;
                    if (data1 !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL dut1_data got %h want %h", data1, e.data);
                    end
                    compared++;
                    if (cyc !== e.cyc) begin
                        mismatched++;
                        $display("[TB] FAIL dut1_latency got cycle %0d want %0d", cyc, e.cyc);
                    end
                end
            end
            if (valid2 | str2 | par2 | stp2) begin
                compared++;
                if (q2.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL dut2_unexpected_pulse got vspt=%b%b%b%b want none",
                             valid2, str2, par2, stp2);
                end else begin
                    e = q2.pop_front();
                    if ({valid2, str2, par2, stp2} !== {e.v, e.s, e.p, e.t}) begin
                        mismatched++;
                        $display("[TB] FAIL dut2_flags got vspt=%b%b%b%b want %b%b%b%b",
                                 valid2, str2, par2, stp2, e.v, e.s, e.p, e.t);
                    end
                    compared++;
                    if (data2 !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL dut2_data got %h want %h", data2, e.data);
                    end
                    compared++;
                    if (cyc !== e.cyc) begin
                        mismatched++;
                        $display("[TB] FAIL dut2_latency got cycle %0d want %0d", cyc, e.cyc);
                    end
                end
            end
        end
    end

    // Reference model for a frame that passed its start bit.
    function automatic exp_t model_frame(input logic [7:0] d, input logic has_par,
                                         input logic ptype, input logic par_b,
                                         input logic [1:0] stops, input int nstop,
                                         input logic [7:0] last);
        exp_t e;
        logic want_par;
        want_par = ptype ? ~(^d) : (^d);
        e.s = 1'b0;
        e.p = has_par && (par_b != want_par);
        e.t = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        e.v = !(e.p || e.t);
        e.data = e.v ? d : last;
        e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t model_start_err(input logic [7:0] last);
        exp_t e;
        e.v = 1'b0; e.s = 1'b1; e.p = 1'b0; e.t = 1'b0;
        e.data = last;
        e.cyc = 0;
        return e;
    endfunction

    task automatic pulse_start(input int sel);
        @(posedge clk); #1;
        if (sel == 0) fs1 = 1'b1; else fs2 = 1'b1;
        @(posedge clk); #1;
        fs1 = 1'b0; fs2 = 1'b0;
    endtask

    // One sample pulse; the last sample of a frame queues its expected event.
    task automatic send_bit(input int sel, input logic b, input logic last, input exp_t e);
        exp_t x;
        @(posedge clk); #1;
        if (last) begin
            x = e;
            x.cyc = cyc + 1;
            if (sel == 0) q1.push_back(x); else q2.push_back(x);
        end
        if (sel == 0) begin sv1 = 1'b1; sb1 = b; end
        else          begin sv2 = 1'b1; sb2 = b; end
        @(posedge clk); #1;
        sv1 = 1'b0; sv2 = 1'b0;
    endtask

    task automatic send_frame(input int sel, input logic start_b, input logic [7:0] d,
                              input logic has_par, input logic par_b,
                              input int nstop, input logic [1:0] stops, input exp_t e);
        pulse_start(sel);
        send_bit(sel, start_b, start_b, e);
        if (!start_b) begin
            for (int i = 0; i < 8; i++) send_bit(sel, d[i], 1'b0, e);
            if (has_par) send_bit(sel, par_b, 1'b0, e);
            for (int i = 0; i < nstop; i++) send_bit(sel, stops[i], (i == nstop - 1), e);
        end
    endtask

    // Waits (bounded) for all queued events to be consumed.
    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        compared++;
        if (q1.size() != 0 || q2.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain_timeout got pending %0d/%0d want 0/0", q1.size(), q2.size());
        end
        q1.delete();
        q2.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if ({data1, valid1, str1, par1, stp1, busy1} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_dut1 got %h/%b%b%b%b/%b want all 0",
                     data1, valid1, str1, par1, stp1, busy1);
        end
        compared++;
        if ({data2, valid2, str2, par2, stp2, busy2} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_dut2 got %h/%b%b%b%b/%b want all 0",
                     data2, valid2, str2, par2, stp2, busy2);
        end
`ifdef RX_ERR_STICKY_EN
        compared++;
        if (sticky1 !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_sticky got %b want 000", sticky1);
        end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_good_frames();
        exp_t e;
        pe1 = 1'b0; pt1 = 1'b0;
        e = model_frame(8'hA5, 1'b0, 1'b0, 1'b0, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'hA5, 1'b0, 1'b0, 1, 2'b01, e);
        last1 = e.data;
        drain();
        pe1 = 1'b1; pt1 = 1'b1;
        e = model_frame(8'h07, 1'b1, 1'b1, 1'b0, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'h07, 1'b1, 1'b0, 1, 2'b01, e);
        last1 = e.data;
        drain();
        compared++;
        if (busy1 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL busy_after_frame got %b want 0", busy1);
        end
        pe1 = 1'b0; pt1 = 1'b0;
    endtask

    task automatic test_start_err();
        exp_t e;
        e = model_start_err(last1);
        send_frame(0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 2'b01, e);
        drain();
        compared++;
        if (busy1 !== 1'b0 || data1 !== last1) begin
            mismatched++;
            $display("[TB] FAIL start_err_state got busy=%b data=%h want busy=0 data=%h",
                     busy1, data1, last1);
        end
    endtask

    task automatic test_parity_err();
        exp_t e;
`ifdef RX_ERR_STICKY_EN
        @(posedge clk); #1; clr1 = 1'b1;
        @(posedge clk); #1; clr1 = 1'b0;
`endif
        pe1 = 1'b1; pt1 = 1'b0;
        e = model_frame(8'h03, 1'b1, 1'b0, 1'b1, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'h03, 1'b1, 1'b1, 1, 2'b01, e);
        drain();
        compared++;
        if (data1 !== last1) begin
            mismatched++;
            $display("[TB] FAIL parity_err_data_held got %h want %h", data1, last1);
        end
`ifdef RX_ERR_STICKY_EN
        repeat (3) @(negedge clk);
        compared++;
        if (sticky1 !== 3'b010) begin
            mismatched++;
            $display("[TB] FAIL sticky_after_par got %b want 010", sticky1);
        end
        @(posedge clk); #1; clr1 = 1'b1;
        @(posedge clk); #1; clr1 = 1'b0;
        @(negedge clk);
        compared++;
        if (sticky1 !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL sticky_after_clr got %b want 000", sticky1);
        end
`endif
        pe1 = 1'b0;
    endtask

    task automatic test_two_stop();
        exp_t e;
        pe2 = 1'b0; pt2 = 1'b0;
        e = model_frame(8'h3C, 1'b0, 1'b0, 1'b0, 2'b11, 2, last2);
        send_frame(1, 1'b0, 8'h3C, 1'b0, 1'b0, 2, 2'b11, e);
        last2 = e.data;
        drain();
        e = model_frame(8'hC3, 1'b0, 1'b0, 1'b0, 2'b01, 2, last2);
        send_frame(1, 1'b0, 8'hC3, 1'b0, 1'b0, 2, 2'b01, e);
        last2 = e.data;
        drain();
        e = model_frame(8'h99, 1'b0, 1'b0, 1'b0, 2'b10, 2, last2);
        send_frame(1, 1'b0, 8'h99, 1'b0, 1'b0, 2, 2'b10, e);
        last2 = e.data;
        drain();
    endtask

    task automatic test_latched_config();
        exp_t e;
        logic [7:0] d;
        d = 8'h03;
        pe1 = 1'b1; pt1 = 1'b0;
        e = model_frame(d, 1'b1, 1'b0, 1'b0, 2'b01, 1, last1);
        pulse_start(0);
        send_bit(0, 1'b0, 1'b0, e);
        for (int i = 0; i < 8; i++) begin
            send_bit(0, d[i], 1'b0, e);
            if (i == 3) begin
                pt1 = 1'b1; pe1 = 1'b0;
                pulse_start(0);
            end
        end
        send_bit(0, 1'b0, 1'b0, e);
        send_bit(0, 1'b1, 1'b1, e);
        last1 = e.data;
        drain();
        pe1 = 1'b0; pt1 = 1'b0;
    endtask

    task automatic test_idle_sample_ignored();
        exp_t e;
        logic [7:0] d;
        d = 8'h96;
        e = model_frame(d, 1'b0, 1'b0, 1'b0, 2'b01, 1, last1);
        @(posedge clk); #1;
        fs1 = 1'b1; sv1 = 1'b1; sb1 = 1'b1;
        @(posedge clk); #1;
        fs1 = 1'b0; sv1 = 1'b0;
        send_bit(0, 1'b0, 1'b0, e);
        for (int i = 0; i < 8; i++) send_bit(0, d[i], 1'b0, e);
        send_bit(0, 1'b1, 1'b1, e);
        last1 = e.data;
        drain();
    endtask

    task automatic test_mid_reset();
        exp_t e;
        pulse_start(0);
        send_bit(0, 1'b0, 1'b0, e);
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1, 1'b0, e);
        compared++;
        if (busy1 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_in_data got %b want 1", busy1);
        end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        compared++;
        if ({data1, valid1, str1, par1, stp1, busy1} !== 13'd0) begin
            mismatched++;
            $display("[TB] FAIL mid_reset_outputs got %h/%b%b%b%b/%b want all 0",
                     data1, valid1, str1, par1, stp1, busy1);
        end
        last1 = 8'h00;
        last2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        e = model_frame(8'h5A, 1'b0, 1'b0, 1'b0, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'h5A, 1'b0, 1'b0, 1, 2'b01, e);
        last1 = e.data;
        drain();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        e = model_frame(8'h81, 1'b0, 1'b0, 1'b0, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'h81, 1'b0, 1'b0, 1, 2'b01, e);
        last1 = e.data;
        e = model_frame(8'h42, 1'b0, 1'b0, 1'b0, 2'b00, 1, last1);
        send_frame(0, 1'b0, 8'h42, 1'b0, 1'b0, 1, 2'b00, e);
        last1 = e.data;
        e = model_frame(8'hFF, 1'b0, 1'b0, 1'b0, 2'b01, 1, last1);
        send_frame(0, 1'b0, 8'hFF, 1'b0, 1'b0, 1, 2'b01, e);
        last1 = e.data;
        drain();
        compared++;
        if (data1 !== 8'hFF) begin
            mismatched++;
            $display("[TB] FAIL back_to_back_final got %h want ff", data1);
        end
    endtask

    // Hard stop in case a task never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fs1 = 1'b0; sv1 = 1'b0; sb1 = 1'b1; pe1 = 1'b0; pt1 = 1'b0;
        fs2 = 1'b0; sv2 = 1'b0; sb2 = 1'b1; pe2 = 1'b0; pt2 = 1'b0;
`ifdef RX_ERR_STICKY_EN
        clr1 = 1'b0; clr2 = 1'b0;
`endif
        test_reset();
        test_good_frames();
        test_start_err();
        test_parity_err();
        test_two_stop();
        test_latched_config();
        test_idle_sample_ignored();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
